// File: rtl/addac_acumulador.sv
// Sequential add/subtract accumulator: takes a frame of CONTAGEM operands over
// valid/ready, accumulates modulo 2^ACC_W with a sticky carry/borrow flag, and
// holds the result until it is acknowledged.
module addac_acumulador #(
  parameter int LARGURA  = 4,
  parameter int CONTAGEM = 4,
  localparam int ACC_W   = (CONTAGEM > 1) ? LARGURA + $clog2(CONTAGEM) : LARGURA + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LARGURA-1:0] operando,
  input  logic               modo,
  output logic [ACC_W-1:0]   saida,
  output logic               vai_um,
  output logic               saida_valid,
  input  logic               saida_ack,
  output logic               ocupado
);

  localparam int CNT_W = (CONTAGEM > 1) ? $clog2(CONTAGEM) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CONTAGEM - 1);

  typedef enum logic [1:0] {IDLE, ACUM, DONE} state_t;

  state_t           state_q, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [ACC_W:0]   operand_ext;
  logic [ACC_W:0]   acc_nxt;
  logic             accept;
  logic             last_accept;

  assign accept      = in_valid & in_ready;
  assign last_accept = accept & (count == LAST);

  // Bit ACC_W of the widened result is the carry (add) or borrow (subtract).
  assign operand_ext = {{(ACC_W + 1 - LARGURA){1'b0}}, operando};
  assign acc_nxt     = modo ? ({1'b0, acc} - operand_ext) : ({1'b0, acc} + operand_ext);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first, so no path through the case infers a latch.
    state_nxt = state_q;
    unique case (state_q)
      IDLE:    if (start)       state_nxt = ACUM;
      ACUM:    if (last_accept) state_nxt = DONE;
      DONE:    if (saida_ack)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    saida_valid = 1'b0;
    ocupado     = 1'b0;
    unique case (state_q)
      ACUM: begin
        in_ready = 1'b1;
        ocupado  = 1'b1;
      end
      DONE: begin
        saida_valid = 1'b1;
        ocupado     = 1'b1;
      end
      default: ;
    endcase
  end

  // saida is loaded only on the DONE entry edge, so it never shows partial sums.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      count  <= '0;
      vai_um <= 1'b0;
      saida  <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        acc    <= '0;
        count  <= '0;
        vai_um <= 1'b0;
      end else if (accept) begin
        acc    <= acc_nxt[ACC_W-1:0];
        vai_um <= vai_um | acc_nxt[ACC_W];
        count  <= last_accept ? '0 : count + CNT_W'(1);
        if (last_accept) saida <= acc_nxt[ACC_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_addac_acumulador.sv
// Directed and randomised checks of addac_acumulador with LARGURA=4,
// CONTAGEM=4 (ACC_W=6); expected values are computed by hand or by a small model.
module tb_addac_acumulador;

  localparam int LARGURA  = 4;
  localparam int CONTAGEM = 4;
  localparam int ACC_W    = 6;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [LARGURA-1:0] operando = '0;
  logic               modo = 1'b0;
  logic [ACC_W-1:0]   saida;
  logic               vai_um;
  logic               saida_valid;
  logic               saida_ack = 1'b0;
  logic               ocupado;

  int n_vec = 0;
  int n_err = 0;

  addac_acumulador #(.LARGURA(LARGURA), .CONTAGEM(CONTAGEM)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .operando(operando), .modo(modo), .saida(saida),
    .vai_um(vai_um), .saida_valid(saida_valid), .saida_ack(saida_ack),
    .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("frame_start_ready", {31'b0, in_ready}, 1);
  endtask

  task automatic send(input int op, input bit md);
    in_valid = 1'b1;
    operando = LARGURA'(op);
    modo     = md;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic ack_frame();
    saida_ack = 1'b1;
    tick();
    saida_ack = 1'b0;
    check("ack_valid_drop", {31'b0, saida_valid}, 0);
    check("ack_idle", {31'b0, ocupado}, 0);
  endtask

  function automatic logic [31:0] outs();
    return {22'b0, saida, vai_um, saida_valid, in_ready, ocupado};
  endfunction

  int m_acc;
  bit m_flag;

  task automatic model_step(input int op, input bit md);
    int t;
    t = md ? m_acc - op : m_acc + op;
    if (t < 0 || t > 63) m_flag = 1'b1;
    m_acc = t & 63;
  endtask

  initial begin
    // 1. reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      operando = LARGURA'($urandom);
      modo     = 1'($urandom);
      saida_ack = 1'($urandom);
      tick();
      check("reset_outputs", outs(), 0);
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; saida_ack = 1'b0;
    tick();
    check("post_reset_idle", outs(), 0);

    // 2. 3+5+7+9 back-to-back
    start_frame();
    send(3, 0); send(5, 0); send(7, 0);
    check("t2_no_early_valid", {31'b0, saida_valid}, 0);
    check("t2_saida_frozen", {26'b0, saida}, 0);
    send(9, 0);
    check("t2_valid", {31'b0, saida_valid}, 1);
    check("t2_saida", {26'b0, saida}, 24);
    check("t2_vai_um", {31'b0, vai_um}, 0);
    check("t2_ready_done", {31'b0, in_ready}, 0);
    ack_frame();

    // 3. 15 x4, then +2 -5 +1 +1 (borrow on the 2nd op, sticky)
    start_frame();
    for (int i = 0; i < 4; i++) send(15, 0);
    check("t3a_saida", {26'b0, saida}, 60);
    check("t3a_vai_um", {31'b0, vai_um}, 0);
    ack_frame();
    start_frame();
    send(2, 0); send(5, 1); send(1, 0); send(1, 0);
    check("t3b_saida", {26'b0, saida}, 63);
    check("t3b_vai_um", {31'b0, vai_um}, 1);
    ack_frame();

    // 4. gaps between operands, then hold in DONE with noise on inputs
    start_frame();
    for (int i = 1; i <= 4; i++) begin
      send(i, 0);
      if (i < 4) begin
        tick(); tick();
        check("t4_gap_ready", {31'b0, in_ready}, 1);
        check("t4_gap_not_done", {31'b0, saida_valid}, 0);
      end
    end
    check("t4_saida", {26'b0, saida}, 10);
    in_valid = 1'b1; start = 1'b1; operando = 4'd15; modo = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4_hold", {22'b0, saida, vai_um, saida_valid, in_ready}, {22'b0, 6'd10, 1'b0, 1'b1, 1'b0});
    end
    in_valid = 1'b0; start = 1'b0;
    ack_frame();
    check("t4_saida_kept", {26'b0, saida}, 10);

    // 5. reset mid-frame, then a clean frame
    start_frame();
    send(5, 0); send(6, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_reset_outputs", outs(), 0);
    tick();
    check("t5_stays_idle", {31'b0, ocupado}, 0);
    start_frame();
    for (int i = 0; i < 4; i++) send(1, 0);
    check("t5_saida", {26'b0, saida}, 4);
    check("t5_vai_um", {31'b0, vai_um}, 0);
    ack_frame();

    // 6. random frames vs model, with stray start/ack
    for (int f = 0; f < 32; f++) begin
      saida_ack = 1'b1;
      tick();
      saida_ack = 1'b0;
      check("t6_ack_in_idle", {31'b0, ocupado}, 0);
      start_frame();
      m_acc = 0; m_flag = 1'b0;
      for (int k = 0; k < CONTAGEM; k++) begin
        int gap, op;
        bit md;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          start = 1'($urandom);
          tick();
          start = 1'b0;
        end
        op = $urandom_range(0, 15);
        md = 1'($urandom_range(0, 1));
        model_step(op, md);
        start = 1'($urandom);
        send(op, md);
        start = 1'b0;
      end
      check("t6_valid", {31'b0, saida_valid}, 1);
      check("t6_saida", {26'b0, saida}, 32'(m_acc));
      check("t6_vai_um", {31'b0, vai_um}, {31'b0, m_flag});
      saida_ack = 1'b1;
      start = 1'($urandom);
      tick();
      saida_ack = 1'b0;
      start = 1'b0;
      check("t6_ack_valid_drop", {31'b0, saida_valid}, 0);
      tick();
      check("t6_start_with_ack_ignored", {31'b0, ocupado}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
